// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants for the time-of-day counter and its display decode
package time_pkg;

   // Display codes beyond the plain digits 0-9
   localparam logic [3:0] CODE_BLANK = 4'd10;
   localparam logic [3:0] CODE_DASH  = 4'd11;
   localparam logic [3:0] CODE_A     = 4'd12;
   localparam logic [3:0] CODE_P     = 4'd13;

   // Set-mode FSM states
   localparam logic [1:0] MODE_RUN      = 2'd0;
   localparam logic [1:0] MODE_SET_HOUR = 2'd1;
   localparam logic [1:0] MODE_SET_MIN  = 2'd2;

   // Field selection reported to the blinking displayers
   localparam logic [1:0] FIELD_NONE  = 2'd0;
   localparam logic [1:0] FIELD_HOURS = 2'd1;
   localparam logic [1:0] FIELD_MINS  = 2'd2;

endpackage

// File: rtl/hour_formatter.sv
// rtl/hour_formatter.sv - binary hour to display digits and AM/PM code; TIME_12H_EN selects 12-hour display
module hour_formatter
   import time_pkg::*;
(
   input  logic [4:0] hour,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] ampm
);

`ifdef TIME_12H_EN
   logic [4:0] h12;

   // 12-hour view: 0 and 12 both read as "12", leading zero blanked
   always_comb begin
      if (hour == 5'd0)
         h12 = 5'd12;
      else if (hour > 5'd12)
         h12 = hour - 5'd12;
      else
         h12 = hour;
      ampm = (hour >= 5'd12) ? CODE_P : CODE_A;
      if (h12 >= 5'd10) begin
         hr_tens = 4'd1;
         hr_ones = 4'(h12 - 5'd10);
      end else begin
         hr_tens = CODE_BLANK;
         hr_ones = 4'(h12);
      end
   end
`else
   // 24-hour view: "00".."23" with leading zero, AM/PM field blank
   always_comb begin
      ampm = CODE_BLANK;
      if (hour >= 5'd20) begin
         hr_tens = 4'd2;
         hr_ones = 4'(hour - 5'd20);
      end else if (hour >= 5'd10) begin
         hr_tens = 4'd1;
         hr_ones = 4'(hour - 5'd10);
      end else begin
         hr_tens = 4'd0;
         hr_ones = 4'(hour);
      end
   end
`endif

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day counter with hour/minute set mode; display build chosen by TIME_12H_EN in hour_formatter
module time_keeper
   import time_pkg::*;
#(
   parameter int CLK_HZ = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] ampm,
   output logic [1:0] edit_field,
   output logic       tick_1hz
);

   localparam int             CW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    mode;
   logic [4:0]    hour;
   logic [3:0]    min_t, min_o, sec_t, sec_o;

   logic sec_last, min_last, hour_last;

   assign sec_last  = (sec_t == 4'd5) && (sec_o == 4'd9);
   assign min_last  = (min_t == 4'd5) && (min_o == 4'd9);
   assign hour_last = (hour == 5'd23);

   // Prescaler, time registers and set-mode FSM; a mode press always wins over an inc press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         mode     <= MODE_RUN;
         hour     <= 5'd0;
         min_t    <= 4'd0;
         min_o    <= 4'd0;
         sec_t    <= 4'd0;
         sec_o    <= 4'd0;
         tick_1hz <= 1'b0;
      end else begin
         tick_1hz <= 1'b0;
         case (mode)
            MODE_RUN: begin
               if (cnt == CNT_MAX) begin
                  cnt      <= '0;
                  tick_1hz <= 1'b1;
                  if (sec_o != 4'd9) begin
                     sec_o <= sec_o + 4'd1;
                  end else begin
                     sec_o <= 4'd0;
                     sec_t <= sec_last ? 4'd0 : sec_t + 4'd1;
                  end
                  if (sec_last) begin
                     if (min_o != 4'd9) begin
                        min_o <= min_o + 4'd1;
                     end else begin
                        min_o <= 4'd0;
                        min_t <= min_last ? 4'd0 : min_t + 4'd1;
                     end
                     if (min_last)
                        hour <= hour_last ? 5'd0 : hour + 5'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
               if (btn_mode)
                  mode <= MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
               cnt <= '0;
               if (btn_mode)
                  mode <= MODE_SET_MIN;
               else if (btn_inc)
                  hour <= hour_last ? 5'd0 : hour + 5'd1;
            end
            MODE_SET_MIN: begin
               cnt <= '0;
               if (btn_mode) begin
                  mode  <= MODE_RUN;
                  sec_t <= 4'd0;
                  sec_o <= 4'd0;
               end else if (btn_inc) begin
                  if (min_o != 4'd9) begin
                     min_o <= min_o + 4'd1;
                  end else begin
                     min_o <= 4'd0;
                     min_t <= min_last ? 4'd0 : min_t + 4'd1;
                  end
               end
            end
            default: begin
               cnt  <= '0;
               mode <= MODE_RUN;
            end
         endcase
      end
   end

   // Field being edited, for the blinking displayers
   always_comb begin
      case (mode)
         MODE_SET_HOUR: edit_field = FIELD_HOURS;
         MODE_SET_MIN:  edit_field = FIELD_MINS;
         default:       edit_field = FIELD_NONE;
      endcase
   end

   assign min_tens = min_t;
   assign min_ones = min_o;
   assign sec_tens = sec_t;
   assign sec_ones = sec_o;

   hour_formatter u_hour_formatter (
      .hour    (hour),
      .hr_tens (hr_tens),
      .hr_ones (hr_ones),
      .ampm    (ampm)
   );

endmodule
